// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states, sizing helper.
// No logic, no latency.
// No flow control of its own.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Iteration counter must hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute-stage datapath and the multiply/divide unit.
// Pure wiring, zero latency.
// start is only honoured while busy=0; there is no queueing.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Bit-serial multiply/divide unit owning the architectural HI/LO pair.
// MULT/DIV: WIDTH+1 cycles from accepting edge to done; MTHI/MTLO: done on the accepting edge.
// busy=1 while iterating; start is dropped (not queued) while busy.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_sign_pq;   // product / quotient needs negation
    logic             r_sign_r;    // remainder needs negation
    logic             r_b_zero;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_opd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [W2-1:0]    r_acc;       // {upper: partial product / remainder, lower: multiplier / quotient}

    op_e              w_op;
    logic             w_op_signed;
    logic             w_op_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_upper;
    logic [WIDTH-1:0] w_lower;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_add_x;
    logic [WIDTH:0]   w_add_y;
    logic             w_add_ci;
    logic [WIDTH+1:0] w_add_full;
    logic [WIDTH:0]   w_add_sum;
    logic             w_add_co;
    logic [W2-1:0]    w_acc_step;
    logic [WIDTH-1:0] w_neg_lo;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Operand decode and sign-magnitude conversion at issue time.
    assign w_op        = op_e'(bus.op);
    assign w_op_signed = ~bus.op[0];
    assign w_op_div    = bus.op[1];
    assign w_a_neg     = w_op_signed & bus.a[WIDTH-1];
    assign w_b_neg     = w_op_signed & bus.b[WIDTH-1];
    assign w_b_zero    = (bus.b == '0);
    // A divide by zero keeps the raw dividend so it falls out unchanged as the remainder.
    assign w_mag_a     = (w_a_neg && !(w_op_div && w_b_zero)) ? -bus.a : bus.a;
    assign w_mag_b     = w_b_neg ? -bus.b : bus.b;

    assign w_upper = r_acc[W2-1:WIDTH];
    assign w_lower = r_acc[WIDTH-1:0];
    assign w_shift = {w_upper, w_lower[WIDTH-1]};

    // Shared WIDTH+1-bit adder; the extra carry-out bit is the divide's "no borrow" flag.
    assign w_add_full = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(WIDTH + 1){1'b0}}, w_add_ci};
    assign w_add_sum  = w_add_full[WIDTH:0];
    assign w_add_co   = w_add_full[WIDTH+1];

    // Adder operand select: shift-add, trial subtract, or upper-half negation in FIX.
    always_comb begin
        w_add_x  = {1'b0, w_upper};
        w_add_y  = '0;
        w_add_ci = 1'b0;
        if (r_state == CALC) begin
            if (r_is_div) begin
                w_add_x  = w_shift;
                w_add_y  = ~{1'b0, r_opd};
                w_add_ci = 1'b1;
            end else if (w_lower[0]) begin
                w_add_y = {1'b0, r_opd};
            end
        end else if (r_state == FIX) begin
            // Upper half of a 2W negation takes the carry out of ~lower+1, i.e. lower==0.
            w_add_x  = {1'b0, ~w_upper};
            w_add_ci = r_is_div ? 1'b1 : (w_lower == '0);
        end
    end

    // One iteration of the accumulator: restoring divide step or shift-add multiply step.
    always_comb begin
        w_acc_step = {w_add_sum, w_lower[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_add_co) begin
                w_acc_step = {w_add_sum[WIDTH-1:0], w_lower[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {w_shift[WIDTH-1:0], w_lower[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_neg_lo = -w_lower;

    // Final sign fix-up; divide by zero leaves the raw iteration result alone.
    always_comb begin
        w_fix_hi = w_upper;
        w_fix_lo = w_lower;
        if (!r_is_div) begin
            if (r_sign_pq) begin
                w_fix_hi = w_add_sum[WIDTH-1:0];
                w_fix_lo = w_neg_lo;
            end
        end else if (!r_b_zero) begin
            if (r_sign_r) begin
                w_fix_hi = w_add_sum[WIDTH-1:0];
            end
            if (r_sign_pq) begin
                w_fix_lo = w_neg_lo;
            end
        end
    end

    // Control FSM plus HI/LO ownership; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_sign_pq <= 1'b0;
            r_sign_r  <= 1'b0;
            r_b_zero  <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_opd     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        case (w_op)
                            OP_MTHI: begin
                                r_hi   <= bus.a;
                                r_done <= 1'b1;
                                r_dbz  <= 1'b0;
                            end
                            OP_MTLO: begin
                                r_lo   <= bus.a;
                                r_done <= 1'b1;
                                r_dbz  <= 1'b0;
                            end
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_is_div  <= w_op_div;
                                r_b_zero  <= w_b_zero;
                                r_sign_pq <= w_a_neg ^ w_b_neg;
                                r_sign_r  <= w_a_neg;
                                r_acc     <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
                                r_opd     <= w_op_div ? w_mag_b : w_mag_a;
                                r_cnt     <= CW'(WIDTH - 1);
                                r_dbz     <= 1'b0;
                                r_state   <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    r_acc <= w_acc_step;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_dbz   <= r_is_div & r_b_zero;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
